// File: rtl/sample_frame_writer_pkg.sv
// ============================================================================
// Module : sample_frame_writer_pkg
// Brief  : Shared frame geometry constants and writer state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sample_frame_writer_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int FRAME_LEN = 1024;

  typedef logic [0:0] state_t;
  localparam state_t FILL      = 1'b0;
  localparam state_t WAIT_SWAP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sample_bank_ram.sv
// ============================================================================
// Module : sample_bank_ram
// Brief  : Two-bank simple dual-port RAM; bank select is the address MSB.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sample_bank_ram
  import sample_frame_writer_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AW    = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/sample_frame_writer.sv
// ============================================================================
// Module : sample_frame_writer
// Brief  : Packs a sample stream into ping-pong frames for the FFT reader.
//          Option macro SAMPLE_FRAME_WRITER_DROP_EN: drop instead of stall.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sample_frame_writer #(
  parameter int DATA_W    = sample_frame_writer_pkg::DATA_W,
  parameter int ADDR_W    = sample_frame_writer_pkg::ADDR_W,
  parameter int FRAME_LEN = sample_frame_writer_pkg::FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  input  logic [ADDR_W-1:0] read_addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              start_o,
  input  logic              release_i,
  output logic              frame_busy_o
`ifdef SAMPLE_FRAME_WRITER_DROP_EN
 ,output logic [15:0]       drop_count_o
`endif
);

  import sample_frame_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_bank;
  logic              rd_bank;
  logic              owned;
  logic              write_en;
  logic              last_write;
  logic              swap;

`ifdef SAMPLE_FRAME_WRITER_DROP_EN
  assign sample_ready_o = 1'b1;
  assign write_en       = sample_valid_i && (state == FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_o <= '0;
    end else if (sample_valid_i && (state == WAIT_SWAP) && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'd1;
    end
  end
`else
  assign sample_ready_o = (state == FILL);
  assign write_en       = sample_valid_i && sample_ready_o;
`endif

  assign last_write = write_en && (wr_ptr == LAST_PTR);
  // A coincident release frees the read bank in time for an immediate swap.
  assign swap = ((state == FILL) && last_write && (!owned || release_i)) ||
                ((state == WAIT_SWAP) && release_i);
  assign frame_busy_o = owned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b1;
      owned   <= 1'b0;
      start_o <= 1'b0;
    end else begin
      start_o <= swap;
      if (write_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (swap) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
        owned   <= 1'b1;
      end else if (release_i) begin
        owned   <= 1'b0;
      end
      if (state == FILL) begin
        if (last_write && !swap) state <= WAIT_SWAP;
      end else if (release_i) begin
        state <= FILL;
      end
    end
  end

  sample_bank_ram #(
    .WIDTH (DATA_W),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_en),
    .wr_addr ({wr_bank, wr_ptr}),
    .wr_data (sample_i),
    .rd_addr ({rd_bank, read_addr_i}),
    .rd_data (data_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_sample_frame_writer.sv
// ============================================================================
// Module : tb_sample_frame_writer
// Brief  : Directed self-checking bench for sample_frame_writer.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sample_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [9:0]  read_addr = '0;
  logic [15:0] data;
  logic        start;
  logic        release_p = 1'b0;
  logic        frame_busy;
`ifdef SAMPLE_FRAME_WRITER_DROP_EN
  logic [15:0] drop_count;
`endif

  int tests = 0;
  int fails = 0;
  int start_count = 0;
  int bad_ready = 0;

  always #5 clk = ~clk;

  sample_frame_writer dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .sample_ready_o (sample_ready),
    .read_addr_i    (read_addr),
    .data_o         (data),
    .start_o        (start),
    .release_i      (release_p),
    .frame_busy_o   (frame_busy)
`ifdef SAMPLE_FRAME_WRITER_DROP_EN
   ,.drop_count_o   (drop_count)
`endif
  );

  always @(negedge clk) if (start === 1'b1) start_count++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n samples base+i back to back; optional release with the last one.
  task automatic send_frame(input int base, input int n, input bit rel_last);
    bad_ready = 0;
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample       = 16'(base + i);
      release_p    = rel_last && (i == n - 1);
      if (sample_ready !== 1'b1) bad_ready++;
      tick();
    end
    sample_valid = 1'b0;
    release_p    = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input int exp);
    read_addr = 10'(addr);
    tick();
    check(tag, 32'(data), 32'(exp));
  endtask

  initial begin
    // 1: asynchronous reset takes effect mid-cycle
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy",  32'(frame_busy), 32'd0);
    check("rst_data",  32'(data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // 2: frame 0, immediate hand-over
    sample_valid = 1'b1;
    bad_ready = 0;
    for (int i = 0; i < 1024; i++) begin
      sample = 16'(i);
      if (sample_ready !== 1'b1) bad_ready++;
      tick();
      if (i == 1022) check("f0_no_early_start", 32'(start), 32'd0);
    end
    sample_valid = 1'b0;
    check("f0_ready_all", 32'(bad_ready), 32'd0);
    check("f0_start", 32'(start), 32'd1);
    check("f0_busy", 32'(frame_busy), 32'd1);
    tick();
    check("f0_start_one_cycle", 32'(start), 32'd0);
    check("f0_start_count", 32'(start_count), 32'd1);
    read_check("f0_rd5", 5, 5);
    read_check("f0_rd1023", 1023, 1023);

    // 3: frame 1 without release -> backpressure until release
    send_frame(2000, 1024, 1'b0);
    check("f1_ready_fill", 32'(bad_ready), 32'd0);
    check("f1_no_start", 32'(start), 32'd0);
    check("f1_busy", 32'(frame_busy), 32'd1);
`ifdef SAMPLE_FRAME_WRITER_DROP_EN
    check("f1_ready_drop", 32'(sample_ready), 32'd1);
`else
    check("f1_ready_low", 32'(sample_ready), 32'd0);
    sample_valid = 1'b1;
    sample = 16'hBEEF;
    repeat (3) tick();
    sample_valid = 1'b0;
    check("f1_ready_held_low", 32'(sample_ready), 32'd0);
`endif
    read_check("f1_old_bank_rd0", 0, 0);
    release_p = 1'b1;
    tick();
    release_p = 1'b0;
    check("f1_start_after_rel", 32'(start), 32'd1);
    check("f1_ready_back", 32'(sample_ready), 32'd1);
    read_check("f1_rd0", 0, 2000);
    check("f1_start_count", 32'(start_count), 32'd2);

    // 4: release coinciding with the last sample, then stray release
    send_frame(3000, 1024, 1'b1);
    check("f2_start", 32'(start), 32'd1);
    check("f2_ready", 32'(sample_ready), 32'd1);
    check("f2_busy", 32'(frame_busy), 32'd1);
    tick();
    check("f2_busy_kept", 32'(frame_busy), 32'd1);
    read_check("f2_rd1", 1, 3001);
    release_p = 1'b1;
    tick();
    release_p = 1'b0;
    check("rel_busy_clear", 32'(frame_busy), 32'd0);
    release_p = 1'b1;
    tick();
    release_p = 1'b0;
    check("stray_rel_busy", 32'(frame_busy), 32'd0);
    check("stray_rel_start", 32'(start), 32'd0);
    check("stray_rel_ready", 32'(sample_ready), 32'd1);
    check("f2_start_count", 32'(start_count), 32'd3);

    // 5: reset after a partial frame
    send_frame(4000, 500, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    check("mid_rst_busy", 32'(frame_busy), 32'd0);
    check("mid_rst_start", 32'(start), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("mid_rst_no_start", 32'(start_count), 32'd3);
    send_frame(5000, 1024, 1'b0);
    check("f3_start", 32'(start), 32'd1);
    read_check("f3_rd0", 0, 5000);
    read_check("f3_rd499", 499, 5499);
    check("f3_start_count", 32'(start_count), 32'd4);

`ifdef SAMPLE_FRAME_WRITER_DROP_EN
    // 6: samples arriving in WAIT_SWAP are dropped and counted
    send_frame(6000, 1024, 1'b0);
    check("d_wait_no_start", 32'(start), 32'd0);
    send_frame(7000, 1030, 1'b0);
    check("d_ready_all", 32'(bad_ready), 32'd0);
    check("d_drop_count", 32'(drop_count), 32'd1030);
    check("d_no_start", 32'(start), 32'd0);
    release_p = 1'b1;
    tick();
    release_p = 1'b0;
    check("d_start", 32'(start), 32'd1);
    read_check("d_rd0", 0, 6000);
    release_p = 1'b1;
    tick();
    release_p = 1'b0;
    send_frame(8000, 1024, 1'b0);
    check("d_next_start", 32'(start), 32'd1);
    read_check("d_next_rd0", 0, 8000);
    check("d_count_stable", 32'(drop_count), 32'd1030);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_frame_writer.md
Name: sample_frame_writer

Overview:
- Producer-side counterpart of the FFT input-buffer reader. Accepts a stream of 16-bit samples over a valid/ready handshake and packs them into 1024-sample frames.
- Uses a ping-pong buffer: two banks. The FFT reads one bank by address while the next frame fills the other.
- Pulses start_o to the FFT when a frame is handed over. Takes the bank back when the FFT signals release (driven by fft_done).

Parameters:
- DATA_W, 16, sample and read-data width.
- ADDR_W, 10, frame address width.
- FRAME_LEN, 1024, samples per frame; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_i  in  DATA_W  incoming sample.
- sample_valid_i  in  1  sample_i is valid this cycle.
- sample_ready_o  out  1  block can accept a sample this cycle.
- read_addr_i  in  ADDR_W  FFT read address into the handed-over bank.
- data_o  out  DATA_W  registered read data.
- start_o  out  1  one-cycle pulse: a frame is ready in the read bank.
- release_i  in  1  one-cycle pulse: FFT has finished with the read bank.
- frame_busy_o  out  1  read bank is currently owned by the FFT.

Behaviour:
- Reset values: sample_ready_o=1, start_o=0, data_o=0, frame_busy_o=0. Internally: wr_ptr=0, wr_bank=0, rd_bank=1, owned=0, state=FILL.
- Sample acceptance:
  - A sample is accepted when sample_valid_i && sample_ready_o.
  - It is written to RAM[{wr_bank, wr_ptr}], then wr_ptr increments.
  - wr_ptr wraps FRAME_LEN-1 -> 0 on the last accepted sample.
- Read path: data_o = RAM[{rd_bank, read_addr_i}], 1-cycle latency. It is valid regardless of owned.
- State FILL:
  - sample_ready_o=1.
  - On the last accepted sample (wr_ptr==FRAME_LEN-1):
    - If the swap condition holds (owned==0, or release_i==1 in the same cycle), perform the swap next cycle and stay in FILL.
    - Otherwise go to WAIT_SWAP.
- State WAIT_SWAP:
  - sample_ready_o=0; samples are backpressured.
  - On release_i: perform the swap the next cycle and go to FILL.
- Swap (one registered update):
  - rd_bank <= wr_bank, wr_bank <= ~wr_bank, owned <= 1.
  - start_o=1 for exactly that one cycle.
  - Resulting start_o timing: start_o is high the cycle after the final write, or the cycle after release_i in WAIT_SWAP.
- Release handling:
  - release_i while owned==0 is ignored.
  - release_i while owned==1 and no swap is pending: owned <= 0 next cycle.
  - If release_i coincides with a swap cycle, the swap wins: owned stays 1.
- frame_busy_o = owned, registered.
- Read/write collision: the write bank and read bank always differ after the first swap. Before the first swap, reads return bank 1 (contents undefined after power-up; not checked).
- Reset mid-operation:
  - The partial frame is discarded, ownership is dropped, and no start_o is issued.
  - RAM contents are not cleared.
- start_o never pulses twice without an intervening swap; at most one frame is outstanding to the FFT.

Optional Feature:
- Macro: SAMPLE_FRAME_WRITER_DROP_EN.
- Defined:
  - sample_ready_o is tied to 1.
  - In WAIT_SWAP, valid samples are discarded and not written.
  - Added output drop_count_o (16 bit) counts discarded samples and saturates at 16'hFFFF. It is cleared by rst only.
  - The FILL/swap behaviour is unchanged.
- Undefined: backpressure as described above; drop_count_o does not exist.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W and FRAME_LEN constants.
  - State typedef {FILL, WAIT_SWAP}.
- Sub-module sample_bank_ram:
  - Simple dual-port RAM, depth 2*FRAME_LEN, width DATA_W.
  - One write port and one registered read port; bank select is the address MSB.
  - Infers block RAM; no reset on its contents.

Test Plan:
1. Reset check: assert rst mid-cycle -> outputs immediately at reset values: ready=1, start_o=0, frame_busy_o=0.
2. Fill frame 0:
   - Stimulus: 1024 samples, value=index, valid held high.
   - start_o high exactly one cycle after the 1024th accept; frame_busy_o=1.
   - Read addr 5 -> data_o=5 one cycle later; addr 1023 -> 1023.
3. Backpressure:
   - Stimulus: fill frame 1 (values 2000+index) without release.
   - sample_ready_o drops after the 1024th accept of frame 1.
   - release_i pulse -> start_o the next cycle and ready=1 again.
   - Read addr 0 returns 2000.
4. Simultaneous events:
   - Stimulus: release_i coincides with the last sample of a frame.
   - No WAIT_SWAP is entered; start_o fires the next cycle; frame_busy_o stays 1.
   - Stray release_i while frame_busy_o=0 -> no change.
5. Reset mid-frame:
   - Stimulus: rst after 500 samples.
   - No start_o is issued.
   - A following complete 1024-sample frame gives start_o with data at addr 0 equal to the first post-reset sample.
6. With DROP_EN:
   - Stimulus: 1030 samples sent while WAIT_SWAP is held.
   - sample_ready_o stays 1; drop_count_o=1030.
   - After release_i, the next frame's addr 0 holds the first sample after the swap.
